// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Receives an instruction image over a UART (8N1) and writes it, one
//   32-bit word per strobe, into an instruction memory. Framing on the wire:
//   sync byte 0xA5, word count N (1..MEM_WORDS), then N little-endian words.
//
// Ports
//   CLK    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset (release synchronised to CLK)
//   rx     in   UART serial input, idle high, asynchronous to CLK
//   WE     out  memory write strobe, one cycle per word
//   A      out  byte address of the written word (index * 4)
//   WD     out  written word, valid while WE=1
//   busy   out  load in progress (core held in reset)
//   done   out  last load completed
//   err    out  last load aborted
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int MEM_WORDS    = 20
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        rx,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]     MAX_N     = 8'(MEM_WORDS);
  localparam logic [7:0]     SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_DONE, S_ERR} state_e;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so every flop
  // leaves reset in the same cycle.
  // ---------------------------------------------------------------------------
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};  // LSB arrives first
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load protocol FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (byte_valid_q && rx_shift_q == SYNC_BYTE) begin
          state_d    = S_COUNT;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          idx_d      = '0;
          byte_cnt_d = '0;
        end
      end
      S_COUNT: begin
        if (frame_err_q) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (byte_valid_q) begin
          if (rx_shift_q != 8'd0 && rx_shift_q <= MAX_N) begin
            n_d        = rx_shift_q;
            state_d    = S_DATA;
            byte_cnt_d = '0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (frame_err_q) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (byte_valid_q) begin
          // Little-endian: first byte ends up in bits [7:0] after four shifts.
          word_d     = {rx_shift_q, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            // The index guard keeps a corrupted count from ever writing
            // outside the memory.
            if (idx_q < MAX_N) begin
              state_d = S_WRITE;
              we_d    = 1'b1;
              a_d     = {22'd0, idx_q, 2'b00};
              wd_d    = word_d;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q + 8'd1 == n_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d    = S_DATA;
          byte_cnt_d = '0;
          // The receiver is free-running, so a byte landing here is taken as
          // the first byte of the next word instead of being dropped.
          if (frame_err_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (byte_valid_q) begin
            word_d     = {rx_shift_q, word_q[31:8]};
            byte_cnt_d = 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      a_q        <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      we_q       <= we_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign WE   = we_q;
  assign A    = a_q;
  assign WD   = wd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
